// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Schedules the common data bus among the four execution-unit result
//   sources (0=ALU, 1=MUL, 2=DIV, 3=LSU). At most one pending result is
//   granted per cycle, using a rotating-priority search, and the granted
//   result is driven onto the CDB through an output register (latency 1).
//
// Parameters:
//   TAG_W   result tag width (64-entry tag FIFO -> 6)
//   DATA_W  result data width
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   <src>_req/_tag/_data           pending result from each source
//   alu_branch/_branch_taken       ALU result resolves a branch (taken)
//   alu_jalr, alu_store_pc         ALU result is a JALR target / needs PC+4
//   <src>_grant                    combinational grant, one-hot or zero
//   cdb_valid/_tag/_data           registered CDB beat
//   cdb_branch/_branch_taken/_jalr/_store_pc  registered ALU flags
//
// Optional feature:
//   CDB_ARB_BRANCH_PRIO_EN  when defined, an ALU request carrying
//   alu_branch or alu_jalr is granted ahead of the rotating search.
//
// Handshake: a source raises <src>_req with stable tag/data/flags and holds
// them until the cycle its <src>_grant is high; that cycle is the transfer.
// The beat appears on the CDB one cycle later. In the cycle after its grant
// a source may present its next result with req still high.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_req,
   input  logic              mul_req,
   input  logic              div_req,
   input  logic              lsu_req,
   input  logic [TAG_W-1:0]  alu_tag,
   input  logic [TAG_W-1:0]  mul_tag,
   input  logic [TAG_W-1:0]  div_tag,
   input  logic [TAG_W-1:0]  lsu_tag,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [DATA_W-1:0] mul_data,
   input  logic [DATA_W-1:0] div_data,
   input  logic [DATA_W-1:0] lsu_data,
   input  logic              alu_branch,
   input  logic              alu_branch_taken,
   input  logic              alu_jalr,
   input  logic              alu_store_pc,
   output logic              alu_grant,
   output logic              mul_grant,
   output logic              div_grant,
   output logic              lsu_grant,
   output logic              cdb_valid,
   output logic [TAG_W-1:0]  cdb_tag,
   output logic [DATA_W-1:0] cdb_data,
   output logic              cdb_branch,
   output logic              cdb_branch_taken,
   output logic              cdb_jalr,
   output logic              cdb_store_pc
);

   logic [1:0]        ptr;
   logic [3:0]        req_vec;
   logic [3:0]        grant_vec;
   logic [1:0]        gnt_idx;
   logic              gnt_any;
   logic [1:0]        scan_idx;
   logic [TAG_W-1:0]  sel_tag;
   logic [DATA_W-1:0] sel_data;

   assign req_vec = {lsu_req, div_req, mul_req, alu_req};

   // Rotating search starting at ptr; the first requester found wins.
   always_comb begin
      grant_vec = '0;
      gnt_idx   = '0;
      gnt_any   = 1'b0;
      scan_idx  = '0;
      for (int k = 0; k < 4; k++) begin
         scan_idx = ptr + 2'(k);
         if (!gnt_any && req_vec[scan_idx]) begin
            gnt_any = 1'b1;
            gnt_idx = scan_idx;
         end
      end
`ifdef CDB_ARB_BRANCH_PRIO_EN
      // Dispatch is stalled on a branch/JALR resolution, so it jumps the queue.
      if (alu_req && (alu_branch || alu_jalr)) begin
         gnt_any = 1'b1;
         gnt_idx = 2'd0;
      end
`endif
      // No grant while in reset: the request stays pending and is not lost.
      if (rst) begin
         gnt_any = 1'b0;
      end
      if (gnt_any) begin
         grant_vec[gnt_idx] = 1'b1;
      end
   end

   assign alu_grant = grant_vec[0];
   assign mul_grant = grant_vec[1];
   assign div_grant = grant_vec[2];
   assign lsu_grant = grant_vec[3];

   always_comb begin
      sel_tag  = alu_tag;
      sel_data = alu_data;
      case (gnt_idx)
         2'd1: begin
            sel_tag  = mul_tag;
            sel_data = mul_data;
         end
         2'd2: begin
            sel_tag  = div_tag;
            sel_data = div_data;
         end
         2'd3: begin
            sel_tag  = lsu_tag;
            sel_data = lsu_data;
         end
         default: begin
            sel_tag  = alu_tag;
            sel_data = alu_data;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr              <= 2'd0;
         cdb_valid        <= 1'b0;
         cdb_tag          <= '0;
         cdb_data         <= '0;
         cdb_branch       <= 1'b0;
         cdb_branch_taken <= 1'b0;
         cdb_jalr         <= 1'b0;
         cdb_store_pc     <= 1'b0;
      end else if (gnt_any) begin
         ptr       <= gnt_idx + 2'd1;
         cdb_valid <= 1'b1;
         cdb_tag   <= sel_tag;
         cdb_data  <= sel_data;
         if (gnt_idx == 2'd0) begin
            cdb_branch       <= alu_branch;
            // Taken is only meaningful on a branch result.
            cdb_branch_taken <= alu_branch & alu_branch_taken;
            cdb_jalr         <= alu_jalr;
            cdb_store_pc     <= alu_store_pc;
         end else begin
            cdb_branch       <= 1'b0;
            cdb_branch_taken <= 1'b0;
            cdb_jalr         <= 1'b0;
            cdb_store_pc     <= 1'b0;
         end
      end else begin
         // Flags are consumed ungated downstream, so they must drop with valid.
         // Tag and data hold.
         cdb_valid        <= 1'b0;
         cdb_branch       <= 1'b0;
         cdb_branch_taken <= 1'b0;
         cdb_jalr         <= 1'b0;
         cdb_store_pc     <= 1'b0;
      end
   end

endmodule
